plc_scan_ctrl: RTL

Sequences the PLC processor through the classic scan cycle: restart program, latch inputs, execute, commit outputs, then idle until the configured scan period expires. Sits beside the CPU top level.
- cpu_rst is ORed into the program counter/stack reset.
- cpu_run gates instruction execution.
- in_latch and out_commit strobe the I/O port snapshot and output registers.
- A watchdog traps programs that never reach the END instruction.

---
 rtl/plc_scan_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/plc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// plc_scan_ctrl
// Sequences the PLC processor through its scan cycle:
//   RESTART -> LATCH_IN -> EXEC -> COMMIT -> (WAIT) -> RESTART / IDLE
// A watchdog traps programs that never reach the END instruction.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   en           run request; scans start while high
//   period       minimum scan length in cycles (0 = free-running)
//   end_of_scan  one-cycle END pulse from the instruction decoder
//   fault_clr    clears the watchdog fault (only acted on in FAULT)
//   cpu_rst      holds CPU program counter / stack in reset
//   cpu_run      CPU execute enable
//   in_latch     one-cycle strobe: snapshot physical inputs
//   out_commit   one-cycle strobe: transfer output image to pins
//   busy         high in every state except IDLE and FAULT
//   wdt_fault    watchdog fault flag (held while in FAULT)
//   scan_cnt     completed scans, wraps
//   scan_time    length in cycles of the last completed scan (RESTART..COMMIT)
// -----------------------------------------------------------------------------
module plc_scan_ctrl #(
    parameter int WDT_LIMIT    = 1000,
    parameter int WDT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    end_of_scan,
    input  logic                    fault_clr,
    output logic                    cpu_rst,
    output logic                    cpu_run,
    output logic                    in_latch,
    output logic                    out_commit,
    output logic                    busy,
    output logic                    wdt_fault,
    output logic [CNT_WIDTH-1:0]    scan_cnt,
    output logic [PERIOD_WIDTH-1:0] scan_time
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESTART  = 3'd1,
        S_LATCH_IN = 3'd2,
        S_EXEC     = 3'd3,
        S_COMMIT   = 3'd4,
        S_WAIT     = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [WDT_WIDTH-1:0]    r_wdt;
    logic [PERIOD_WIDTH-1:0] r_t;
    logic [PERIOD_WIDTH:0]   w_t_inc;
    logic [PERIOD_WIDTH-1:0] w_t_sat;
    logic                    w_period_done;
    logic                    w_wdt_expired;

    logic w_cpu_rst;
    logic w_cpu_run;
    logic w_in_latch;
    logic w_out_commit;
    logic w_busy;
    logic w_wdt_fault;

    // t+1 computed one bit wider so the period compare never wraps.
    assign w_t_inc       = {1'b0, r_t} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
    assign w_t_sat       = w_t_inc[PERIOD_WIDTH] ? {PERIOD_WIDTH{1'b1}} : w_t_inc[PERIOD_WIDTH-1:0];
    assign w_period_done = (w_t_inc >= {1'b0, period});
    // Counter holds (EXEC cycles already completed), so value LIMIT-1 marks
    // the LIMIT-th EXEC cycle.
    assign w_wdt_expired = (r_wdt == WDT_WIDTH'(WDT_LIMIT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) w_next = S_RESTART;
                else    w_next = S_IDLE;
            end
            S_RESTART:  w_next = S_LATCH_IN;
            S_LATCH_IN: w_next = S_EXEC;
            S_EXEC: begin
                // END wins over a watchdog expiry in the same cycle.
                if (end_of_scan)        w_next = S_COMMIT;
                else if (w_wdt_expired) w_next = S_FAULT;
                else                    w_next = S_EXEC;
            end
            S_COMMIT, S_WAIT: begin
                if (w_period_done) w_next = en ? S_RESTART : S_IDLE;
                else               w_next = S_WAIT;
            end
            S_FAULT: begin
                if (fault_clr) w_next = S_IDLE;
                else           w_next = S_FAULT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode of the upcoming state, so the registered outputs
    // line up with the state register.
    always_comb begin
        w_cpu_rst    = 1'b1;
        w_cpu_run    = 1'b0;
        w_in_latch   = 1'b0;
        w_out_commit = 1'b0;
        w_busy       = 1'b1;
        w_wdt_fault  = 1'b0;
        case (w_next)
            S_IDLE:     w_busy = 1'b0;
            S_RESTART:  w_busy = 1'b1;
            S_LATCH_IN: w_in_latch = 1'b1;
            S_EXEC: begin
                w_cpu_rst = 1'b0;
                w_cpu_run = 1'b1;
            end
            S_COMMIT: begin
                w_cpu_rst    = 1'b0;
                w_out_commit = 1'b1;
            end
            S_WAIT:     w_busy = 1'b1;
            S_FAULT: begin
                w_busy      = 1'b0;
                w_wdt_fault = 1'b1;
            end
            default:    w_busy = 1'b0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rst    <= 1'b1;
            cpu_run    <= 1'b0;
            in_latch   <= 1'b0;
            out_commit <= 1'b0;
            busy       <= 1'b0;
            wdt_fault  <= 1'b0;
        end else begin
            cpu_rst    <= w_cpu_rst;
            cpu_run    <= w_cpu_run;
            in_latch   <= w_in_latch;
            out_commit <= w_out_commit;
            busy       <= w_busy;
            wdt_fault  <= w_wdt_fault;
        end
    end

    // Elapsed-scan timer: 0 in RESTART, then counts up and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t <= {PERIOD_WIDTH{1'b0}};
        end else if (w_next == S_RESTART) begin
            r_t <= {PERIOD_WIDTH{1'b0}};
        end else begin
            r_t <= w_t_sat;
        end
    end

    // Watchdog counter: cleared at scan start, counts EXEC cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdt <= {WDT_WIDTH{1'b0}};
        end else if (w_next == S_RESTART) begin
            r_wdt <= {WDT_WIDTH{1'b0}};
        end else if (r_state == S_EXEC) begin
            r_wdt <= r_wdt + WDT_WIDTH'(1);
        end else begin
            r_wdt <= r_wdt;
        end
    end

    // Scan statistics, updated only by a completed scan's COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= {CNT_WIDTH{1'b0}};
            scan_time <= {PERIOD_WIDTH{1'b0}};
        end else if (r_state == S_COMMIT) begin
            scan_cnt  <= scan_cnt + CNT_WIDTH'(1);
            scan_time <= w_t_sat;
        end else begin
            scan_cnt  <= scan_cnt;
            scan_time <= scan_time;
        end
    end

endmodule
